// File: rtl/multiexp_ctrl.sv
// multiexp_ctrl -- sequencer for a windowed double-and-add multi-scalar
// multiplication, sum(s_i * P_i), using external add/double units and two RAMs.
//
// Windows run k = NWIN-1 down to 0. Inside each window the inputs run
// i = 0 .. NUM_IN-1. The accumulator is doubled W_BITS times at the start of
// each window. Each input's digit then selects a precomputed multiple d*P_i
// from the point table, and that multiple is added into the accumulator.
//
// Optional build macro: MULTIEXP_PERF_CNT_EN adds the performance counters
// o_cyc_cnt, o_add_cnt and o_dbl_cnt.
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_val / o_rdy        start request / controller idle
//   o_val / i_rdy        result valid / result accepted
//   o_p, o_inf, o_err    result point, result is infinity, arithmetic error
//   o_scl_re/_a, i_scl_d scalar RAM read port (read latency RD_LAT)
//   o_pnt_re/_a, i_pnt_d point-table RAM read port, entry i*2^W_BITS+d = d*P_i
//   o_add_*, i_add_*     add unit: request (p1 + p2), response (p, err)
//   o_dbl_*, i_dbl_*     double unit: request (p), response (p, err)
//   o_cyc_cnt, o_add_cnt, o_dbl_cnt   perf counters (MULTIEXP_PERF_CNT_EN only)
//
// state  | meaning
// IDLE   | ready for a start request
// DBL    | W_BITS sequential doubles of acc (skipped while acc is infinity)
// RD_SCL | read scalar s_i and extract the digit of window k
// RD_PNT | read d*P_i from the point table (loaded directly if acc is infinity)
// ADD    | acc <= acc + d*P_i through the add unit
// DONE   | result presented until accepted
module multiexp_ctrl #(
    parameter int PNT_BITS = 512,
    parameter int DAT_BITS = 256,
    parameter int W_BITS   = 4,
    parameter int NUM_IN   = 16,
    parameter int RD_LAT   = 2,
    localparam int IW      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_val,
    output logic                 o_rdy,
    output logic                 o_val,
    input  logic                 i_rdy,
    output logic [PNT_BITS-1:0]  o_p,
    output logic                 o_inf,
    output logic                 o_err,
    output logic                 o_scl_re,
    output logic [IW-1:0]        o_scl_a,
    input  logic [DAT_BITS-1:0]  i_scl_d,
    output logic                 o_pnt_re,
    output logic [IW+W_BITS-1:0] o_pnt_a,
    input  logic [PNT_BITS-1:0]  i_pnt_d,
    output logic                 o_add_val,
    input  logic                 i_add_rdy,
    output logic [PNT_BITS-1:0]  o_add_p1,
    output logic [PNT_BITS-1:0]  o_add_p2,
    input  logic                 i_add_val,
    input  logic [PNT_BITS-1:0]  i_add_p,
    input  logic                 i_add_err,
    output logic                 o_add_rdy,
    output logic                 o_dbl_val,
    input  logic                 i_dbl_rdy,
    output logic [PNT_BITS-1:0]  o_dbl_p,
    input  logic                 i_dbl_val,
    input  logic [PNT_BITS-1:0]  i_dbl_p,
    input  logic                 i_dbl_err,
    output logic                 o_dbl_rdy
`ifdef MULTIEXP_PERF_CNT_EN
    ,
    output logic [31:0]          o_cyc_cnt,
    output logic [31:0]          o_add_cnt,
    output logic [31:0]          o_dbl_cnt
`endif
);

    localparam int NWIN = DAT_BITS / W_BITS;
    localparam int KW   = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int JW   = (W_BITS > 1) ? $clog2(W_BITS) : 1;
    localparam int LW   = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DBL    = 3'd1,
        RD_SCL = 3'd2,
        RD_PNT = 3'd3,
        ADD    = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [PNT_BITS-1:0]  acc_q, acc_d;
    logic                 acc_inf_q, acc_inf_d;
    logic [PNT_BITS-1:0]  pnt_q, pnt_d;
    logic [KW-1:0]        k_q, k_d;
    logic [IW-1:0]        i_q, i_d;
    logic [JW-1:0]        j_q, j_d;
    logic [W_BITS-1:0]    digit_q, digit_d;
    logic                 wait_q, wait_d;     // request accepted, awaiting response
    logic                 iss_q, iss_d;       // RAM read issued, data not yet sampled
    logic [LW-1:0]        lat_q, lat_d;       // read latency down-counter
    logic                 err_q, err_d;
    logic                 rdy_en_q;           // keeps o_rdy low during the reset cycle
    logic                 adv;
    logic [W_BITS-1:0]    scl_digit;

    assign scl_digit = i_scl_d[int'(k_q) * W_BITS +: W_BITS];

    assign o_scl_a  = i_q;
    assign o_pnt_a  = {i_q, digit_q};
    assign o_add_p1 = acc_q;
    assign o_add_p2 = pnt_q;
    assign o_dbl_p  = acc_q;
    assign o_p      = acc_q;
    assign o_inf    = (state_q == DONE) && acc_inf_q;
    assign o_err    = err_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            acc_inf_q <= 1'b0;
            pnt_q     <= '0;
            k_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            digit_q   <= '0;
            wait_q    <= 1'b0;
            iss_q     <= 1'b0;
            lat_q     <= '0;
            err_q     <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_inf_q <= acc_inf_d;
            pnt_q     <= pnt_d;
            k_q       <= k_d;
            i_q       <= i_d;
            j_q       <= j_d;
            digit_q   <= digit_d;
            wait_q    <= wait_d;
            iss_q     <= iss_d;
            lat_q     <= lat_d;
            err_q     <= err_d;
            rdy_en_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_inf_d = acc_inf_q;
        pnt_d     = pnt_q;
        k_d       = k_q;
        i_d       = i_q;
        j_d       = j_q;
        digit_d   = digit_q;
        wait_d    = wait_q;
        iss_d     = iss_q;
        lat_d     = (lat_q != '0) ? lat_q - LW'(1) : lat_q;
        err_d     = err_q;
        adv       = 1'b0;
        o_rdy     = 1'b0;
        o_val     = 1'b0;
        o_scl_re  = 1'b0;
        o_pnt_re  = 1'b0;
        o_add_val = 1'b0;
        o_add_rdy = 1'b0;
        o_dbl_val = 1'b0;
        o_dbl_rdy = 1'b0;

        case (state_q)
            IDLE: begin
                o_rdy = rdy_en_q;
                if (i_val && rdy_en_q) begin
                    acc_inf_d = 1'b1;
                    k_d       = KW'(NWIN - 1);
                    i_d       = '0;
                    j_d       = '0;
                    err_d     = 1'b0;
                    wait_d    = 1'b0;
                    iss_d     = 1'b0;
                    state_d   = DBL;
                end
            end

            DBL: begin
                if (acc_inf_q) begin
                    state_d = RD_SCL;
                end else if (!wait_q) begin
                    o_dbl_val = 1'b1;
                    if (i_dbl_rdy) wait_d = 1'b1;
                end else begin
                    o_dbl_rdy = 1'b1;
                    if (i_dbl_val) begin
                        wait_d = 1'b0;
                        if (i_dbl_err) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            acc_d = i_dbl_p;
                            if (j_q == JW'(W_BITS - 1)) begin
                                j_d     = '0;
                                state_d = RD_SCL;
                            end else begin
                                j_d = j_q + JW'(1);
                            end
                        end
                    end
                end
            end

            RD_SCL: begin
                if (!iss_q) begin
                    o_scl_re = 1'b1;
                    iss_d    = 1'b1;
                    lat_d    = LW'(RD_LAT);
                end else if (lat_q == LW'(1)) begin
                    iss_d   = 1'b0;
                    digit_d = scl_digit;
                    // A zero digit contributes nothing: skip the table read.
                    if (scl_digit == '0) adv = 1'b1;
                    else                 state_d = RD_PNT;
                end
            end

            RD_PNT: begin
                if (!iss_q) begin
                    o_pnt_re = 1'b1;
                    iss_d    = 1'b1;
                    lat_d    = LW'(RD_LAT);
                end else if (lat_q == LW'(1)) begin
                    iss_d = 1'b0;
                    // Infinity + X = X, so the first contribution is loaded directly.
                    if (acc_inf_q) begin
                        acc_d     = i_pnt_d;
                        acc_inf_d = 1'b0;
                        adv       = 1'b1;
                    end else begin
                        pnt_d   = i_pnt_d;
                        state_d = ADD;
                    end
                end
            end

            ADD: begin
                if (!wait_q) begin
                    o_add_val = 1'b1;
                    if (i_add_rdy) wait_d = 1'b1;
                end else begin
                    o_add_rdy = 1'b1;
                    if (i_add_val) begin
                        wait_d = 1'b0;
                        if (i_add_err) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            acc_d = i_add_p;
                            adv   = 1'b1;
                        end
                    end
                end
            end

            DONE: begin
                o_val = 1'b1;
                if (i_rdy) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        if (adv) begin
            if (i_q == IW'(NUM_IN - 1)) begin
                i_d = '0;
                if (k_q == '0) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q - KW'(1);
                    state_d = DBL;
                end
            end else begin
                i_d     = i_q + IW'(1);
                state_d = RD_SCL;
            end
        end
    end

`ifdef MULTIEXP_PERF_CNT_EN
    logic [31:0] cyc_cnt_q, add_cnt_q, dbl_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cyc_cnt_q <= '0;
            add_cnt_q <= '0;
            dbl_cnt_q <= '0;
        end else if (state_q == IDLE && state_d == DBL) begin
            cyc_cnt_q <= '0;
            add_cnt_q <= '0;
            dbl_cnt_q <= '0;
        end else begin
            if (state_q != IDLE && state_q != DONE) cyc_cnt_q <= cyc_cnt_q + 32'd1;
            if (o_add_val && i_add_rdy)             add_cnt_q <= add_cnt_q + 32'd1;
            if (o_dbl_val && i_dbl_rdy)             dbl_cnt_q <= dbl_cnt_q + 32'd1;
        end
    end

    assign o_cyc_cnt = cyc_cnt_q;
    assign o_add_cnt = add_cnt_q;
    assign o_dbl_cnt = dbl_cnt_q;
`endif

endmodule
